unified_mem_arbiter: RTL

Sequencer that shares one single-ported, variable-latency memory between the pipeline's instruction-fetch stage and its MEM stage (loads/stores). It sits between the pipeline and the unified memory. It grants one transaction at a time with fixed data-over-fetch priority and holds the memory request stable until the memory acknowledges. It also produces the per-requester stall signals that freeze the pipeline, and handles fetch cancellation on redirect plus a memory-timeout error.

---
 rtl/unified_mem_arbiter.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/unified_mem_arbiter.sv
// -----------------------------------------------------------------------------
// unified_mem_arbiter
//
// Shares one single-ported, variable-latency memory between the instruction
// fetch stage and the MEM (load/store) stage. One transaction is in flight at
// a time; data requests win over fetch requests, and a transaction in flight
// is never preempted. The memory request is registered and held stable until
// the memory acknowledges (or the wait counter reaches TIMEOUT). Each
// transaction ends with a one-cycle DONE state that pulses the owner's valid.
//
// Ports
//   clk, reset             clock; synchronous active-high reset
//   if_req/if_addr         fetch request, held until if_valid
//   if_flush               redirect: cancels the pending/in-flight fetch
//   if_valid/if_rdata      fetch completion pulse and instruction word
//   if_stall               if_req & ~if_valid
//   d_req/d_we/d_addr/
//   d_wdata                data request (load or store), held until d_valid
//   d_valid/d_rdata        data completion pulse and load data
//   d_stall                d_req & ~d_valid
//   mem_req/mem_we/
//   mem_addr/mem_wdata     registered request to the unified memory
//   mem_ready/mem_rdata    memory completion and read data
//   err_timeout            sticky: some transaction hit the timeout
// -----------------------------------------------------------------------------
module unified_mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    input  logic          if_flush,
    output logic          if_valid,
    output logic [DW-1:0] if_rdata,
    output logic          if_stall,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_valid,
    output logic [DW-1:0] d_rdata,
    output logic          d_stall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ready,
    input  logic [DW-1:0] mem_rdata,
    output logic          err_timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

    // owner: 0 = fetch, 1 = data. kill: the in-flight fetch was redirected.
    state_t        state,       state_n;
    logic          owner,       owner_n;
    logic          kill,        kill_n;
    logic [15:0]   cnt,         cnt_n;
    logic          mem_req_n,   mem_we_n;
    logic [AW-1:0] mem_addr_n;
    logic [DW-1:0] mem_wdata_n;
    logic [DW-1:0] if_rdata_n,  d_rdata_n;
    logic          err_n;

    // -------------------------------------------------------------------------
    // Next-state and next-register computation
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_n     = state;
        owner_n     = owner;
        kill_n      = kill;
        cnt_n       = cnt;
        mem_req_n   = mem_req;
        mem_we_n    = mem_we;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        if_rdata_n  = if_rdata;
        d_rdata_n   = d_rdata;
        err_n       = err_timeout;

        unique case (state)
            IDLE: begin
                if (d_req) begin
                    state_n     = DBUSY;
                    owner_n     = 1'b1;
                    kill_n      = 1'b0;
                    cnt_n       = '0;
                    mem_req_n   = 1'b1;
                    mem_we_n    = d_we;
                    mem_addr_n  = d_addr;
                    mem_wdata_n = d_wdata;
                end else if (if_req && !if_flush) begin
                    state_n    = IBUSY;
                    owner_n    = 1'b0;
                    kill_n     = 1'b0;
                    cnt_n      = '0;
                    mem_req_n  = 1'b1;
                    mem_we_n   = 1'b0;
                    mem_addr_n = if_addr;
                end
            end

            IBUSY, DBUSY: begin
                cnt_n = cnt + 16'd1;
                // A redirect cannot abort the memory cycle; it only hides
                // the result from the fetch stage.
                if (state == IBUSY && if_flush) begin
                    kill_n = 1'b1;
                end
                if (mem_ready || cnt == TIMEOUT_CNT) begin
                    state_n   = DONE;
                    mem_req_n = 1'b0;
                    mem_we_n  = 1'b0;
                    if (mem_ready) begin
                        if (!owner) begin
                            if_rdata_n = mem_rdata;
                        end else if (!mem_we) begin
                            d_rdata_n = mem_rdata;
                        end
                    end else begin
                        err_n = 1'b1;
                        if (owner) begin
                            d_rdata_n = '0;
                        end else begin
                            if_rdata_n = '0;
                        end
                    end
                end
            end

            DONE: begin
                // No issue from DONE: a requester still holding req while it
                // sees valid must not be served twice.
                state_n = IDLE;
            end

            default: state_n = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            state       <= IDLE;
            owner       <= 1'b0;
            kill        <= 1'b0;
            cnt         <= '0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            if_rdata    <= '0;
            d_rdata     <= '0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_n;
            owner       <= owner_n;
            kill        <= kill_n;
            cnt         <= cnt_n;
            mem_req     <= mem_req_n;
            mem_we      <= mem_we_n;
            mem_addr    <= mem_addr_n;
            mem_wdata   <= mem_wdata_n;
            if_rdata    <= if_rdata_n;
            d_rdata     <= d_rdata_n;
            err_timeout <= err_n;
        end
    end

    // -------------------------------------------------------------------------
    // Completion pulses and stalls (decoded from registered state)
    // -------------------------------------------------------------------------
    assign if_valid = (state == DONE) && !owner && !kill;
    assign d_valid  = (state == DONE) && owner;
    assign if_stall = if_req & ~if_valid;
    assign d_stall  = d_req & ~d_valid;

endmodule
